// File: rtl/eco_equiv_sweeper.sv
// Drives every {b,a} vector into two copies of a combinational cone and compares
// their outputs, reporting the mismatch count and the first failing vector.
module eco_equiv_sweeper #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [W-1:0]   cmp_mask,
  output logic [W-1:0]   a_o,
  output logic [W-1:0]   b_o,
  input  logic [W-1:0]   y_ref_i,
  input  logic [W-1:0]   y_rev_i,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic           pass,
  output logic [2*W:0]   mism_cnt,
  output logic [2*W-1:0] first_fail,
  output logic           fail_seen
);

  // state   | meaning
  // IDLE    | waiting for start; results of the last sweep held
  // DRIVE   | current vector on a_o/b_o
  // SETTLE  | waiting SETTLE cycles for the cones to resolve
  // COMPARE | compare masked outputs, advance or finish
  // DONE    | one-cycle done pulse, pass resolved
  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE_ST,
    COMPARE,
    DONE
  } state_t;

  localparam int VW = 2 * W;
  localparam logic [VW-1:0] VEC_ONE  = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] VEC_LAST = '1;
  localparam logic [VW:0]   CNT_ONE  = {{VW{1'b0}}, 1'b1};
  localparam logic [3:0]    SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t         state, state_nxt;
  logic [VW-1:0]  vec, vec_nxt, vec_inc;
  logic [W-1:0]   mask, mask_nxt;
  logic [3:0]     settle_cnt, settle_cnt_nxt;
  logic [W-1:0]   a_nxt, b_nxt;
  logic           busy_nxt, done_nxt, aborted_nxt, pass_nxt, seen_nxt;
  logic [VW:0]    mism_nxt;
  logic [VW-1:0]  first_nxt;
  logic           mismatch, sweep_abort;

  assign vec_inc     = vec + VEC_ONE;
  assign mismatch    = |((y_ref_i ^ y_rev_i) & mask);
  assign sweep_abort = abort && (state == DRIVE || state == SETTLE_ST || state == COMPARE);

  always_comb begin
    state_nxt      = state;
    vec_nxt        = vec;
    mask_nxt       = mask;
    settle_cnt_nxt = settle_cnt;
    a_nxt          = a_o;
    b_nxt          = b_o;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    aborted_nxt    = aborted;
    pass_nxt       = pass;
    mism_nxt       = mism_cnt;
    first_nxt      = first_fail;
    seen_nxt       = fail_seen;

    // Abort outranks everything, including a compare in the same cycle.
    if (sweep_abort) begin
      state_nxt   = DONE;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b1;
      aborted_nxt = 1'b1;
      pass_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt   = DRIVE;
            mask_nxt    = cmp_mask;
            vec_nxt     = '0;
            a_nxt       = '0;
            b_nxt       = '0;
            busy_nxt    = 1'b1;
            aborted_nxt = 1'b0;
            pass_nxt    = 1'b0;
            mism_nxt    = '0;
            first_nxt   = '0;
            seen_nxt    = 1'b0;
          end
        end
        DRIVE: begin
          if (SETTLE > 0) begin
            state_nxt      = SETTLE_ST;
            settle_cnt_nxt = SETTLE_LOAD;
          end else begin
            state_nxt = COMPARE;
          end
        end
        SETTLE_ST: begin
          if (settle_cnt == 4'd0) state_nxt = COMPARE;
          else settle_cnt_nxt = settle_cnt - 4'd1;
        end
        COMPARE: begin
          if (mismatch) begin
            mism_nxt = mism_cnt + CNT_ONE;
            if (!fail_seen) begin
              first_nxt = vec;
              seen_nxt  = 1'b1;
            end
          end
          if (vec == VEC_LAST) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (mism_nxt == '0) && !aborted;
          end else begin
            state_nxt = DRIVE;
            vec_nxt   = vec_inc;
            a_nxt     = vec_inc[W-1:0];
            b_nxt     = vec_inc[VW-1:W];
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      mask       <= '0;
      settle_cnt <= '0;
      a_o        <= '0;
      b_o        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      pass       <= 1'b0;
      mism_cnt   <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      mask       <= mask_nxt;
      settle_cnt <= settle_cnt_nxt;
      a_o        <= a_nxt;
      b_o        <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
      pass       <= pass_nxt;
      mism_cnt   <= mism_nxt;
      first_fail <= first_nxt;
      fail_seen  <= seen_nxt;
    end
  end

endmodule

// File: tb/tb_eco_equiv_sweeper.sv
// Scoreboard bench for eco_equiv_sweeper: two cone copies modelled in the bench,
// expected sweep results queued at start and checked when done pulses.
module tb_eco_equiv_sweeper;

  localparam int W   = 4;
  localparam int S   = 1;
  localparam int PER = S + 2;
  localparam int NV  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, abort = 1'b0;
  logic [W-1:0] cmp_mask = '0;
  logic [W-1:0] a_o, b_o, y_ref, y_rev;
  logic         busy, done, aborted, pass, fail_seen;
  logic [2*W:0] mism_cnt;
  logic [2*W-1:0] first_fail;

  logic         start_s0 = 1'b0, abort_s0 = 1'b0;
  logic [W-1:0] a_s0, b_s0, y_ref_s0, y_rev_s0;
  logic         busy_s0, done_s0, aborted_s0, pass_s0, seen_s0;
  logic [2*W:0] mism_s0;
  logic [2*W-1:0] first_s0;

  logic [3:0] fault_tab [NV];

  function automatic logic [3:0] cone(input logic [3:0] a, input logic [3:0] b);
    return (a * 4'd3) ^ (b + 4'd7) ^ {a[0], b[3:1]};
  endfunction

  assign y_ref    = cone(a_o, b_o);
  assign y_rev    = y_ref ^ fault_tab[{b_o, a_o}];
  assign y_ref_s0 = cone(a_s0, b_s0);
  assign y_rev_s0 = y_ref_s0 ^ fault_tab[{b_s0, a_s0}];

  eco_equiv_sweeper #(.W(W), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cmp_mask(cmp_mask),
    .a_o(a_o), .b_o(b_o), .y_ref_i(y_ref), .y_rev_i(y_rev),
    .busy(busy), .done(done), .aborted(aborted), .pass(pass),
    .mism_cnt(mism_cnt), .first_fail(first_fail), .fail_seen(fail_seen)
  );

  eco_equiv_sweeper #(.W(W), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s0), .abort(abort_s0), .cmp_mask(cmp_mask),
    .a_o(a_s0), .b_o(b_s0), .y_ref_i(y_ref_s0), .y_rev_i(y_rev_s0),
    .busy(busy_s0), .done(done_s0), .aborted(aborted_s0), .pass(pass_s0),
    .mism_cnt(mism_s0), .first_fail(first_s0), .fail_seen(seen_s0)
  );

  typedef struct {
    int busy_len;
    bit aborted;
    bit pass;
    int mism;
    bit seen;
    int first;
    int a_last;
    int b_last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the first n_cmp vectors in ascending order against the fault table.
  function automatic exp_t model(input int n_cmp, input logic [3:0] mask, input bit ab,
                                 input int blen, input int vlast);
    exp_t e;
    e.mism = 0;
    e.seen = 1'b0;
    e.first = 0;
    for (int v = 0; v < n_cmp; v++) begin
      if ((fault_tab[v] & mask) != 4'd0) begin
        e.mism++;
        if (!e.seen) begin
          e.seen = 1'b1;
          e.first = v;
        end
      end
    end
    e.aborted  = ab;
    e.pass     = !ab && (e.mism == 0);
    e.busy_len = blen;
    e.a_last   = vlast % 16;
    e.b_last   = vlast / 16;
    return e;
  endfunction

  // Monitor: counts busy cycles, checks results on done, and checks results hold while idle.
  int   busy_cnt = 0;
  exp_t mon_e, idle_e;
  bit   idle_ok = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      idle_ok  = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("busy_len", busy_cnt, mon_e.busy_len);
          check("busy_at_done", int'(busy), 0);
          check("aborted", int'(aborted), int'(mon_e.aborted));
          check("pass", int'(pass), int'(mon_e.pass));
          check("mism_cnt", int'(mism_cnt), mon_e.mism);
          check("fail_seen", int'(fail_seen), int'(mon_e.seen));
          check("first_fail", int'(first_fail), mon_e.first);
          check("a_last", int'(a_o), mon_e.a_last);
          check("b_last", int'(b_o), mon_e.b_last);
          idle_e  = mon_e;
          idle_ok = 1'b1;
        end
        busy_cnt = 0;
      end else if (!busy && idle_ok) begin
        check("idle_hold_mism", int'(mism_cnt), idle_e.mism);
        check("idle_hold_flags", {29'd0, aborted, pass, fail_seen},
              {29'd0, idle_e.aborted, idle_e.pass, idle_e.seen});
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_a_o"}, int'(a_o), 0);
    check({tag, "_b_o"}, int'(b_o), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_aborted"}, int'(aborted), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_mism_cnt"}, int'(mism_cnt), 0);
    check({tag, "_first_fail"}, int'(first_fail), 0);
    check({tag, "_fail_seen"}, int'(fail_seen), 0);
  endtask

  // abort_k: abort is sampled on the k-th rising edge after the start edge (0 = no abort).
  task automatic run_sweep(input logic [3:0] mask, input int abort_k,
                           input bit abort_with_start, input int n_pulses);
    exp_t e;
    int   t;
    if (abort_k == 0) e = model(NV, mask, 1'b0, NV * PER, NV - 1);
    else e = model((abort_k - 1) / PER, mask, 1'b1, abort_k, (abort_k - 1) / PER);
    sb.push_back(e);
    @(negedge clk);
    cmp_mask = mask;
    start    = 1'b1;
    abort    = abort_with_start;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    cmp_mask = 4'($urandom);
    if (abort_k > 0) begin
      repeat (abort_k - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    for (int i = 0; i < n_pulses; i++) begin
      repeat ($urandom_range(1, 100)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_s0(input logic [3:0] mask);
    exp_t e;
    int   t, cnt;
    e = model(NV, mask, 1'b0, NV * 2, NV - 1);
    @(negedge clk);
    cmp_mask = mask;
    start_s0 = 1'b1;
    @(negedge clk);
    start_s0 = 1'b0;
    t   = 0;
    cnt = 0;
    while (!done_s0 && t < 3000) begin
      if (busy_s0) cnt++;
      @(negedge clk);
      t++;
    end
    check("s0_done_timeout", int'(t < 3000), 1);
    check("s0_busy_len", cnt, e.busy_len);
    check("s0_mism_cnt", int'(mism_s0), e.mism);
    check("s0_first_fail", int'(first_s0), e.first);
    check("s0_fail_seen", int'(seen_s0), int'(e.seen));
    check("s0_pass", int'(pass_s0), int'(e.pass));
    check("s0_aborted", int'(aborted_s0), 0);
    check("s0_ab_last", int'({b_s0, a_s0}), e.b_last * 16 + e.a_last);
    @(negedge clk);
  endtask

  task automatic set_faults(input int kind);
    for (int v = 0; v < NV; v++) begin
      case (kind)
        0:       fault_tab[v] = 4'h0;
        1:       fault_tab[v] = (v == 8'h53) ? 4'b0010 : 4'h0;
        2:       fault_tab[v] = 4'hF;
        default: fault_tab[v] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      endcase
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_faults(0);
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    run_sweep(4'hF, 0, 1'b0, 0);
    set_faults(1);
    run_sweep(4'hF, 0, 1'b0, 0);
    run_sweep(4'b1101, 0, 1'b0, 0);
    run_sweep(4'b0010, 0, 1'b0, 0);
    set_faults(2);
    run_sweep(4'hF, 0, 1'b0, 0);
    run_sweep(4'hF, 100, 1'b0, 0);
    set_faults(0);
    run_sweep(4'hF, 0, 1'b0, 3);
    set_faults(2);
    run_sweep(4'h0, 0, 1'b0, 0);
    run_sweep(4'h4, 0, 1'b1, 0);
    set_faults(3);
    run_sweep(4'hF, 1, 1'b0, 0);
    run_sweep(4'hF, NV * PER, 1'b0, 0);

    set_faults(2);
    @(negedge clk);
    start = 1'b1;
    cmp_mask = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_sweep_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    set_faults(1);
    run_s0(4'hF);

    for (int i = 0; i < 6; i++) begin
      set_faults(3);
      if (($urandom_range(0, 1)) == 0) run_sweep(4'($urandom), 0, 1'b0, $urandom_range(0, 4));
      else run_sweep(4'($urandom), $urandom_range(1, NV * PER), 1'b0, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
